step_pulse_master: RTL

//  Avalon-MM initiator that drives a 1-bit PIO output slave (step line) autonomously.
//  - Issues timed write transactions: 1 then 0 per step, for a programmed step count.
//  - Sits between the stepper control logic and the interconnect port of the step PIO.
//  - Frees the CPU from per-pulse register writes.

---
 rtl/step_pkg.sv | 17 +
 rtl/step_hold_timer.sv | 24 ++
 rtl/step_pulse_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Shared FSM encoding, PIO address and level constants for the step pulse master.
package step_pkg;

  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
  localparam logic [31:0] LVL_HI        = 32'd1;
  localparam logic [31:0] LVL_LO        = 32'd0;

  // RD_* are only reachable when the readback option is built in.
  typedef enum logic [2:0] {
    IDLE, WR_HI, HOLD_HI, WR_LO, HOLD_LO, FIN, RD_HI, RD_LO
  } state_e;

  function automatic logic on_bus(input state_e s);
    return (s == WR_HI) || (s == WR_LO) || (s == RD_HI) || (s == RD_LO);
  endfunction

endpackage

// File: rtl/step_hold_timer.sv
// Loadable down-counter that times how long the step line holds each level.
module step_hold_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] val_i,
  output logic             expire_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   cnt_q <= '0;
    else if (load_i)                cnt_q <= val_i;
    else if (en_i && cnt_q != '0)   cnt_q <= cnt_q - DIV_W'(1);
  end

  // Loaded with H on entry, so the last of H hold cycles sees a count of 1.
  assign expire_o = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/step_pulse_master.sv
// Avalon-MM initiator writing 1 then 0 to a step PIO per step, with timed holds.
// Build option STEP_READBACK_EN adds a verify read after every write.
module step_pulse_master
  import step_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter int         DIV_W    = 24,
  parameter logic [1:0] PIO_ADDR = PIO_DATA_ADDR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] step_count,
  input  logic [DIV_W-1:0] half_period,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_done,
  output logic [1:0]       av_address,
  output logic             av_chipselect,
  output logic             av_write_n,
  output logic [31:0]      av_writedata,
  input  logic             av_waitrequest
`ifdef STEP_READBACK_EN
  ,
  output logic             av_read_n,
  input  logic [31:0]      av_readdata,
  output logic             error
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, steps_q, steps_d;
  logic [DIV_W-1:0] hp_q;
  logic             pend_q, pend_d, abort_q, abort_d;
  logic             busy_q, done_q, cs_q, wn_q;
  logic [31:0]      wd_q;
  logic             stop_now, hi_ok, lo_ok, tmr_load, tmr_en, tmr_exp;
`ifdef STEP_READBACK_EN
  logic             rn_q, err_q, err_d;
  logic             unused_rd;
  assign unused_rd = ^av_readdata[31:1];
`endif

  // A stop seen while a write is stalled is remembered until the accept.
  assign stop_now = stop || pend_q;

  step_hold_timer #(.DIV_W(DIV_W)) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .val_i    (hp_q),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    pend_d   = pend_q;
    abort_d  = abort_q;
    hi_ok    = 1'b0;
    lo_ok    = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
`ifdef STEP_READBACK_EN
    err_d    = err_q;
`endif
    if (stop && state_q != IDLE && state_q != FIN) pend_d = 1'b1;
    case (state_q)
      IDLE: if (start) begin
        steps_d = '0;
        pend_d  = 1'b0;
        abort_d = 1'b0;
`ifdef STEP_READBACK_EN
        err_d   = 1'b0;
`endif
        state_d = (step_count == '0) ? FIN : WR_HI;
      end
      WR_HI: if (!av_waitrequest) begin
`ifdef STEP_READBACK_EN
        state_d = RD_HI;
`else
        hi_ok = 1'b1;
`endif
      end
      HOLD_HI: begin
        tmr_en = 1'b1;
        if (stop_now) begin
          state_d = WR_LO;
          abort_d = 1'b1;
        end else if (tmr_exp) begin
          state_d = WR_LO;
        end
      end
      WR_LO: if (!av_waitrequest) begin
        // The forced-low write of a stopped run is not a completed step.
        if (!abort_q && steps_q != cnt_q) steps_d = steps_q + CNT_W'(1);
`ifdef STEP_READBACK_EN
        state_d = RD_LO;
`else
        lo_ok = 1'b1;
`endif
      end
      HOLD_LO: begin
        tmr_en = 1'b1;
        if (stop_now)     state_d = FIN;
        else if (tmr_exp) state_d = WR_HI;
      end
      FIN: state_d = IDLE;
`ifdef STEP_READBACK_EN
      RD_HI: if (!av_waitrequest) begin
        if (av_readdata[0] != LVL_HI[0]) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          hi_ok = 1'b1;
        end
      end
      RD_LO: if (!av_waitrequest) begin
        if (av_readdata[0] != LVL_LO[0]) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          lo_ok = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (hi_ok) begin
      if (stop_now) begin
        state_d = WR_LO;
        abort_d = 1'b1;
      end else begin
        state_d  = HOLD_HI;
        tmr_load = 1'b1;
      end
    end
    if (lo_ok) begin
      if (abort_q || stop_now || steps_d == cnt_q) begin
        state_d = FIN;
      end else begin
        state_d  = HOLD_LO;
        tmr_load = 1'b1;
      end
    end
  end

  // Bus outputs are registered from the next state so they hold through stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      steps_q <= '0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wd_q    <= '0;
`ifdef STEP_READBACK_EN
      rn_q    <= 1'b1;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
      if (state_q == IDLE && start) begin
        cnt_q <= step_count;
        hp_q  <= (half_period == '0) ? DIV_W'(1) : half_period;
      end
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == FIN);
      cs_q   <= on_bus(state_d);
      wn_q   <= !(state_d == WR_HI || state_d == WR_LO);
      wd_q   <= (state_d == WR_HI) ? LVL_HI : LVL_LO;
`ifdef STEP_READBACK_EN
      rn_q   <= !(state_d == RD_HI || state_d == RD_LO);
      err_q  <= err_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign steps_done    = steps_q;
  assign av_address    = PIO_ADDR;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wd_q;
`ifdef STEP_READBACK_EN
  assign av_read_n     = rn_q;
  assign error         = err_q;
`endif

endmodule
